inc_dec_pipe: RTL and testbench

Parametrised, pipelined increment/decrement unit with a per-transaction mode select and a valid/ready handshake. It generalises the team's 24-bit combinational carry-mask incrementer in four ways:

- configurable width and lookahead block size;
- decrement and saturating modes;
- a two-stage registered datapath;
- backpressure support.

It sits in the FP rounding/normalisation path and in address/pointer generators, where a ±1 on a wide operand must close timing at full clock rate.

---
 rtl/inc_dec_pipe.sv | 141 ++++++++++++++
 tb/tb_inc_dec_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/inc_dec_pipe.sv
// inc_dec_pipe: two-stage pipelined +/-1 unit built on a block carry-mask
// structure. S1 registers the operand with per-block propagate flags. S2
// ripples the block carries, forms the in-block prefix mask, applies the
// saturation clamp and registers the result. Valid/ready handshake with
// full-rate throughput and stall hold.
// WIDTH must be a multiple of BLK_W (BLK_W in {2,4,8}, WIDTH >= 4).
module inc_dec_pipe #(
  parameter int WIDTH = 24,
  parameter int BLK_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic             in_cin,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cout,
  output logic             out_sat
);

  localparam int NBLK = WIDTH / BLK_W;

  // Saturating modes clamp on carry/borrow out. The inc clamp (all ones) and
  // the dec clamp (zero) are both equal to the operand in that case, so the
  // clamped result is simply the unmodified operand.
  function automatic logic [WIDTH+1:0] f_sat(
    input logic [WIDTH-1:0] sum,
    input logic [WIDTH-1:0] a,
    input logic             cout,
    input logic             sat_en
  );
    if (sat_en && cout) return {a, 1'b0, 1'b1};
    return {sum, cout, 1'b0};
  endfunction

  // Handshake control
  logic w_s1_adv;
  logic w_s2_adv;
  logic w_accept;
  logic w_load_p2;
  logic r_vld_p1;
  logic r_vld_p2;

  assign w_s2_adv  = !r_vld_p2 || out_ready;
  assign w_s1_adv  = !r_vld_p1 || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign w_accept  = in_valid && w_s1_adv;
  assign w_load_p2 = r_vld_p1 && w_s2_adv;

  // ---- Stage 0 -> 1: block propagate flags and operand capture ----
  logic [NBLK-1:0]  w_bp_p0;
  logic [WIDTH-1:0] r_a_p1;
  logic             r_cin_p1;
  logic [1:0]       r_op_p1;
  logic [NBLK-1:0]  r_bp_p1;

  // Block propagates: all-ones detect for inc, all-zeros detect for dec.
  always_comb begin
    w_bp_p0 = '0;
    for (int b = 0; b < NBLK; b++) begin
      w_bp_p0[b] = in_op[0] ? ~|in_a[b*BLK_W +: BLK_W] : &in_a[b*BLK_W +: BLK_W];
    end
  end

  // Capture the accepted transaction into S1.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a_p1   <= in_a;
      r_cin_p1 <= in_cin;
      r_op_p1  <= in_op;
      r_bp_p1  <= w_bp_p0;
    end
  end

  // ---- Stage 1 -> 2: carry mask, result, saturation ----
  logic [WIDTH-1:0] w_t_p1;
  logic [WIDTH-1:0] w_mask_p1;
  logic [WIDTH-1:0] w_sum_p1;
  logic             w_cout_p1;
  logic [WIDTH+1:0] w_res_p1;

  // Block carries ripple across blocks; inside a block each bit toggles when
  // the block carry-in and all lower in-block bits propagate. Decrement uses
  // the inverted operand so one structure serves both directions.
  always_comb begin : mask_gen
    logic v_c;
    logic v_pre;
    w_t_p1    = r_op_p1[0] ? ~r_a_p1 : r_a_p1;
    w_mask_p1 = '0;
    v_c       = r_cin_p1;
    v_pre     = 1'b0;
    for (int b = 0; b < NBLK; b++) begin
      v_pre = 1'b1;
      for (int i = 0; i < BLK_W; i++) begin
        w_mask_p1[b*BLK_W+i] = v_c & v_pre;
        v_pre = v_pre & w_t_p1[b*BLK_W+i];
      end
      v_c = v_c & r_bp_p1[b];
    end
    w_cout_p1 = v_c;
  end

  assign w_sum_p1 = r_a_p1 ^ w_mask_p1;
  assign w_res_p1 = f_sat(w_sum_p1, r_a_p1, w_cout_p1, r_op_p1[1]);

  logic [WIDTH-1:0] r_data_p2;
  logic             r_cout_p2;
  logic             r_sat_p2;

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_p2 <= '0;
      r_cout_p2 <= 1'b0;
      r_sat_p2  <= 1'b0;
    end else if (w_load_p2) begin
      {r_data_p2, r_cout_p2, r_sat_p2} <= w_res_p1;
    end
  end

  // Stage valids: each stage refills or empties whenever it advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      if (w_s1_adv) r_vld_p1 <= in_valid;
      if (w_s2_adv) r_vld_p2 <= r_vld_p1;
    end
  end

  assign out_valid = r_vld_p2;
  assign out_data  = r_data_p2;
  assign out_cout  = r_cout_p2;
  assign out_sat   = r_sat_p2;

endmodule

// File: tb/tb_inc_dec_pipe.sv
// Testbench for inc_dec_pipe: directed vectors at 24/4, backpressure and
// mid-flight reset, plus a randomized run on 8/2, 24/4 and 32/8 instances
// sharing one handshake, checked against an arithmetic reference model.
module tb_inc_dec_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_a = '0;
  logic        in_cin = 1'b0;
  logic [1:0]  in_op = 2'b00;
  logic        out_ready = 1'b1;

  logic        rdy24, vld24, cout24, sat24;
  logic [23:0] data24;
  logic        rdy8, vld8, cout8, sat8;
  logic [7:0]  data8;
  logic        rdy32, vld32, cout32, sat32;
  logic [31:0] data32;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  inc_dec_pipe #(.WIDTH(24), .BLK_W(4)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy24),
    .in_a(in_a[23:0]), .in_cin(in_cin), .in_op(in_op), .out_valid(vld24),
    .out_ready(out_ready), .out_data(data24), .out_cout(cout24), .out_sat(sat24)
  );

  inc_dec_pipe #(.WIDTH(8), .BLK_W(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .in_a(in_a[7:0]), .in_cin(in_cin), .in_op(in_op), .out_valid(vld8),
    .out_ready(out_ready), .out_data(data8), .out_cout(cout8), .out_sat(sat8)
  );

  inc_dec_pipe #(.WIDTH(32), .BLK_W(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .in_a(in_a), .in_cin(in_cin), .in_op(in_op), .out_valid(vld32),
    .out_ready(out_ready), .out_data(data32), .out_cout(cout32), .out_sat(sat32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: a +/- cin modulo 2^w, with the saturating clamp. Returns {data, cout, sat}.
  function automatic logic [33:0] model(input logic [31:0] a, input logic cin,
                                        input logic [1:0] op, input int w);
    logic [31:0] m, am, r;
    logic c, s;
    m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am = a & m;
    if (!cin) return {am, 1'b0, 1'b0};
    if (!op[0]) begin
      c = (am == m);
      r = (am + 32'd1) & m;
    end else begin
      c = (am == 32'd0);
      r = (am - 32'd1) & m;
    end
    s = 1'b0;
    if (op[1] && c) begin
      r = am;
      c = 1'b0;
      s = 1'b1;
    end
    return {r, c, s};
  endfunction

  task automatic run_vec(input string tag, input logic [31:0] a, input logic cin,
                         input logic [1:0] op, input logic [23:0] exp_d,
                         input logic exp_c, input logic exp_s);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_cin = cin; in_op = op; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_lat"}, vld24, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_vld"}, vld24, 1'b1);
    chk({tag, "_data"}, data24, exp_d);
    chk({tag, "_cout"}, cout24, exp_c);
    chk({tag, "_sat"}, sat24, exp_s);
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic        cin;
    logic [1:0]  op;
  } txn_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got, nsent, r;
    logic acc, fire, held;
    logic [25:0] held_val;
    logic [33:0] e;
    txn_t q[$];
    txn_t t;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_vld", vld24, 1'b0);
    chk("rst_data", data24, 24'h0);
    chk("rst_cout", cout24, 1'b0);
    chk("rst_sat", sat24, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", rdy24, 1'b1);

    // Directed vectors
    run_vec("inc_f",      32'h00000F, 1'b1, 2'b00, 24'h000010, 1'b0, 1'b0);
    run_vec("inc_wrap",   32'hFFFFFF, 1'b1, 2'b00, 24'h000000, 1'b1, 1'b0);
    run_vec("inc_blk",    32'h0FFFFF, 1'b1, 2'b00, 24'h100000, 1'b0, 1'b0);
    run_vec("dec_100",    32'h000100, 1'b1, 2'b01, 24'h0000FF, 1'b0, 1'b0);
    run_vec("dec_wrap",   32'h000000, 1'b1, 2'b01, 24'hFFFFFF, 1'b1, 1'b0);
    run_vec("dec_pass",   32'h123456, 1'b0, 2'b01, 24'h123456, 1'b0, 1'b0);
    run_vec("sinc_clamp", 32'hFFFFFF, 1'b1, 2'b10, 24'hFFFFFF, 1'b0, 1'b1);
    run_vec("sdec_clamp", 32'h000000, 1'b1, 2'b11, 24'h000000, 1'b0, 1'b1);
    run_vec("sinc_mid",   32'h7FFFFF, 1'b1, 2'b10, 24'h800000, 1'b0, 1'b0);
    run_vec("sdec_one",   32'h000001, 1'b1, 2'b11, 24'h000000, 1'b0, 1'b0);
    run_vec("sinc_pass",  32'hFFFFFF, 1'b0, 2'b10, 24'hFFFFFF, 1'b0, 1'b0);

    // Backpressure: 5 incs of 0..4, out_ready low in cycles 3-6
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    sent = 0; got = 0;
    for (int c = 1; c <= 30 && got < 5; c++) begin
      @(negedge clk);
      in_valid = (sent < 5); in_a = 32'(sent); in_cin = 1'b1; in_op = 2'b00;
      out_ready = !(c >= 3 && c <= 6);
      #1;
      if (c == 3) chk("bp_accepts", sent, 2);
      if (c >= 3 && c <= 6) begin
        chk("bp_stall_rdy", rdy24, 1'b0);
        chk("bp_stall_data", data24, 24'h1);
      end
      acc  = in_valid && rdy24;
      fire = vld24 && out_ready;
      if (fire) begin
        got++;
        chk("bp_order", data24, 64'(got));
      end
      if (acc) sent++;
      @(posedge clk);
    end
    chk("bp_count", got, 5);
    chk("bp_sent", sent, 5);

    // Reset with both stages full
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h5; in_cin = 1'b1; in_op = 2'b00; out_ready = 1'b0;
    @(negedge clk);
    in_a = 32'h6;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("full_vld", vld24, 1'b1);
    chk("full_rdy", rdy24, 1'b0);
    chk("full_data", data24, 24'h6);
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", vld24, 1'b0);
    chk("midrst_data", data24, 24'h0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    run_vec("post_rst", 32'h000041, 1'b1, 2'b00, 24'h000042, 1'b0, 1'b0);

    // Randomized run across three parameter sets
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nsent = 0; held = 1'b0; held_val = '0;
    for (int c = 0; c < 20000 && (nsent < 2000 || q.size() > 0); c++) begin
      @(negedge clk);
      in_valid = (nsent < 2000) && ($urandom_range(3) != 0);
      r = int'($urandom_range(7));
      in_a = (r == 0) ? 32'h0 : (r == 1) ? 32'hFFFF_FFFF : (r == 2) ? 32'h00FF_FFFF : $urandom;
      in_cin = ($urandom_range(3) != 0);
      in_op = 2'($urandom_range(3));
      out_ready = ($urandom_range(3) != 0);
      #1;
      if (held) chk("rnd_hold", {data24, cout24, sat24}, held_val);
      if (vld24 && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_spurious", vld24, 1'b0);
        end else begin
          t = q.pop_front();
          e = model(t.a, t.cin, t.op, 24);
          chk("rnd24_data", data24, e[33:2]);
          chk("rnd24_flags", {cout24, sat24}, e[1:0]);
          e = model(t.a, t.cin, t.op, 8);
          chk("rnd8_vld", vld8, 1'b1);
          chk("rnd8_data", data8, e[33:2]);
          chk("rnd8_flags", {cout8, sat8}, e[1:0]);
          e = model(t.a, t.cin, t.op, 32);
          chk("rnd32_vld", vld32, 1'b1);
          chk("rnd32_data", data32, e[33:2]);
          chk("rnd32_flags", {cout32, sat32}, e[1:0]);
        end
      end
      held = vld24 && !out_ready;
      held_val = {data24, cout24, sat24};
      if (in_valid && rdy24) begin
        q.push_back('{a: in_a, cin: in_cin, op: in_op});
        nsent++;
      end
    end
    chk("rnd_drain", q.size(), 0);
    chk("rnd_sent", nsent, 2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
